// File: rtl/omicron_sdram_pkg.sv
// Shared SDRAM client definitions: word geometry, response encoding and arbiter grant type.
package omicron_sdram_pkg;

  localparam int sdram_addr_width = 24;
  localparam int sdram_data_width = 16;

  // Encoding of bwe on the controller response path.
  localparam logic resp_write = 1'b1;
  localparam logic resp_read  = 1'b0;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

endpackage

// File: rtl/sdram_rb_outfifo.sv
// Readback FIFO: first-word-fall-through head, push and pop may coincide at any fill level.
module sdram_rb_outfifo
  import omicron_sdram_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        push,
  input  logic [sdram_data_width-1:0] push_data,
  input  logic                        pop,
  output logic [sdram_data_width-1:0] head_data,
  output logic                        head_valid,
  output logic [$clog2(depth):0]      count
);

  localparam int pw = $clog2(depth);
  localparam logic [pw:0] full_cnt = (pw + 1)'(depth);

  logic [sdram_data_width-1:0] mem [depth];
  logic [pw-1:0] wr_idx, rd_idx;
  logic [pw:0]   cnt;
  logic          do_push, do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != full_cnt) || do_pop);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + pw'(1);
      if (do_pop)  rd_idx <= rd_idx + pw'(1);
      cnt <= cnt + (pw + 1)'(do_push) - (pw + 1)'(do_pop);
    end
  end

  // NOTE: the storage array carries no reset; cnt alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end

  assign head_data  = mem[rd_idx];
  assign head_valid = (cnt != '0);
  assign count      = cnt;

endmodule

// File: rtl/sdram_ringbuf.sv
// Circular capture buffer in SDRAM: arbitrates sample writes and in-order readback reads
// onto one controller request port and collects read data into a small output FIFO.
module sdram_ringbuf
  import omicron_sdram_pkg::*;
#(
  parameter int addr_width = sdram_addr_width,
  parameter int out_depth  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [sdram_data_width-1:0] s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [sdram_data_width-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  input  logic                        flush,
  output logic                        overflow,
  output logic [addr_width:0]         level,
  output logic                        avalid,
  input  logic                        aready,
  output logic                        awe,
  output logic [addr_width-1:0]       aaddr,
  output logic [sdram_data_width-1:0] adata,
  input  logic                        bvalid,
  input  logic                        bwe,
  input  logic [sdram_data_width-1:0] bdata
);

  localparam int cw = $clog2(out_depth) + 1;
  localparam logic [addr_width:0] capacity   = {1'b1, {addr_width{1'b0}}};
  localparam logic [cw:0]         credit_lim = (cw + 1)'(out_depth);

  logic [addr_width-1:0] wr_ptr, rd_ptr;
  logic [addr_width:0]   used;
  logic [cw-1:0]         rd_inflight, discard, fifo_cnt;
  grant_t                last_grant;
  logic                  overflow_q;

  logic wr_req, rd_req, grant_write;
  logic accept, wr_acc, rd_acc, rd_resp;
  logic fifo_push, fifo_pop;

  // Reads stop while stale responses from before a flush are still draining, and
  // are credit-limited so every word in flight is guaranteed a FIFO slot.
  assign wr_req = s_valid && (used != capacity);
  assign rd_req = (used != '0) && (discard == '0)
               && (({1'b0, rd_inflight} + {1'b0, fifo_cnt}) < credit_lim);

  // Round-robin: last_grant only moves on an accept, so a stalled grant holds.
  assign grant_write = wr_req && (!rd_req || (last_grant == GRANT_READ));

  assign avalid  = (wr_req || rd_req) && !flush && !rst;
  assign awe     = grant_write;
  assign aaddr   = grant_write ? wr_ptr : rd_ptr;
  assign adata   = s_data;

  assign accept  = avalid && aready;
  assign wr_acc  = accept && grant_write;
  assign rd_acc  = accept && !grant_write;
  assign s_ready = wr_acc;

  assign rd_resp   = bvalid && (bwe == resp_read);
  assign fifo_push = rd_resp && (discard == '0);
  assign fifo_pop  = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      used        <= '0;
      rd_inflight <= '0;
      discard     <= '0;
      last_grant  <= GRANT_READ;
      overflow_q  <= 1'b0;
    end else if (flush) begin
      // Responses still owed by the controller belong to the old contents.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      used        <= '0;
      overflow_q  <= 1'b0;
      rd_inflight <= rd_inflight - cw'(rd_resp);
      discard     <= rd_inflight - cw'(rd_resp);
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + addr_width'(1);
        used   <= used + (addr_width + 1)'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + addr_width'(1);
        used   <= used - (addr_width + 1)'(1);
      end
      if (accept) last_grant <= grant_write ? GRANT_WRITE : GRANT_READ;
      rd_inflight <= rd_inflight + cw'(rd_acc) - cw'(rd_resp);
      if (rd_resp && (discard != '0)) discard <= discard - cw'(1);
      if (s_valid && (used == capacity)) overflow_q <= 1'b1;
    end
  end

  assign level    = used;
  assign overflow = overflow_q;

  sdram_rb_outfifo #(
    .depth(out_depth)
  ) u_outfifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (fifo_push),
    .push_data (bdata),
    .pop       (fifo_pop),
    .head_data (m_data),
    .head_valid(m_valid),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_sdram_ringbuf.sv
// Directed bench for sdram_ringbuf: a behavioural SDRAM controller with fixed response
// latency serves one of two DUT instances (full-size and 16-word) selected per test.
`timescale 1ns/1ps
module tb_sdram_ringbuf;

  localparam int aw_big   = 24;
  localparam int aw_small = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic        flush   = 1'b0;
  logic        aready  = 1'b0;
  logic        b_valid = 1'b0;
  logic        b_we    = 1'b0;
  logic [15:0] b_data  = '0;
  int          sel     = 0;

  logic              big_s_ready, big_m_valid, big_overflow, big_avalid, big_awe;
  logic [15:0]       big_m_data, big_adata;
  logic [aw_big:0]   big_level;
  logic [aw_big-1:0] big_aaddr;

  logic                small_s_ready, small_m_valid, small_overflow, small_avalid, small_awe;
  logic [15:0]         small_m_data, small_adata;
  logic [aw_small:0]   small_level;
  logic [aw_small-1:0] small_aaddr;

  sdram_ringbuf #(.addr_width(aw_big), .out_depth(4)) dut_big (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(big_s_ready),
    .m_data(big_m_data), .m_valid(big_m_valid), .m_ready(m_ready), .flush(flush),
    .overflow(big_overflow), .level(big_level), .avalid(big_avalid), .aready(aready),
    .awe(big_awe), .aaddr(big_aaddr), .adata(big_adata),
    .bvalid(b_valid && (sel == 0)), .bwe(b_we), .bdata(b_data)
  );

  sdram_ringbuf #(.addr_width(aw_small), .out_depth(4)) dut_small (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(small_s_ready),
    .m_data(small_m_data), .m_valid(small_m_valid), .m_ready(m_ready), .flush(flush),
    .overflow(small_overflow), .level(small_level), .avalid(small_avalid), .aready(aready),
    .awe(small_awe), .aaddr(small_aaddr), .adata(small_adata),
    .bvalid(b_valid && (sel == 1)), .bwe(b_we), .bdata(b_data)
  );

  logic        v_s_ready, v_m_valid, v_overflow, v_avalid, v_awe;
  logic [15:0] v_m_data, v_adata;
  int          v_level, v_aaddr;

  always_comb begin
    v_s_ready = big_s_ready;  v_m_valid = big_m_valid; v_overflow = big_overflow;
    v_avalid  = big_avalid;   v_awe     = big_awe;     v_m_data   = big_m_data;
    v_adata   = big_adata;    v_level   = int'(big_level); v_aaddr = int'(big_aaddr);
    if (sel == 1) begin
      v_s_ready = small_s_ready; v_m_valid = small_m_valid; v_overflow = small_overflow;
      v_avalid  = small_avalid;  v_awe     = small_awe;     v_m_data   = small_m_data;
      v_adata   = small_adata;   v_level   = int'(small_level); v_aaddr = int'(small_aaddr);
    end
  end

  // Controller model: accepts on avalid && aready, answers in order after lat cycles.
  typedef struct {
    int          due;
    bit          we;
    logic [15:0] data;
  } resp_t;

  resp_t       rq[$];
  logic [15:0] mem [32];
  int          cyc = 0;
  int          lat = 1;
  int          waddr_q[$], raddr_q[$], pop_q[$];
  bit          grant_q[$];
  int          rd_total = 0, pop_total = 0, max_out = 0, rd_resp_cnt = 0;
  bit          mv_seen = 1'b0;

  always @(negedge clk) begin
    resp_t r;
    cyc++;
    b_valid = 1'b0;
    if (rst) begin
      rq.delete();
    end else begin
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        b_valid = 1'b1;
        b_we    = r.we;
        b_data  = r.data;
        if (!r.we) rd_resp_cnt++;
      end
      if (v_avalid && aready) begin
        r.due = cyc + lat;
        r.we  = v_awe;
        grant_q.push_back(v_awe);
        if (v_awe) begin
          mem[v_aaddr % 32] = v_adata;
          r.data = 16'h0;
          waddr_q.push_back(v_aaddr);
        end else begin
          r.data = mem[v_aaddr % 32];
          raddr_q.push_back(v_aaddr);
          rd_total++;
        end
        rq.push_back(r);
      end
      if (v_m_valid) mv_seen = 1'b1;
      if (v_m_valid && m_ready) begin
        pop_q.push_back(int'(v_m_data));
        pop_total++;
      end
      if (rd_total - pop_total > max_out) max_out = rd_total - pop_total;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int which);
    rst = 1'b1; s_valid = 1'b0; flush = 1'b0; m_ready = 1'b0; aready = 1'b0;
    tick(2);
    sel = which;
    waddr_q.delete(); raddr_q.delete(); pop_q.delete(); grant_q.delete();
    rd_total = 0; pop_total = 0; max_out = 0; rd_resp_cnt = 0; mv_seen = 1'b0;
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = v_s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_pops(input int n, input string tag);
    for (int i = 0; i < 400 && pop_q.size() < n; i++) tick(1);
    check(tag, 32'(pop_q.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values with a sample already offered.
    s_valid = 1'b1;
    #2;
    check("rst_s_ready", 32'(v_s_ready), 32'd0);
    check("rst_avalid", 32'(v_avalid), 32'd0);
    check("rst_m_valid", 32'(v_m_valid), 32'd0);
    check("rst_level", 32'(v_level), 32'd0);
    check("rst_overflow", 32'(v_overflow), 32'd0);

    // Test 1: 8 samples with consumer stalled; reads interleave until the 4-word credit is spent.
    do_reset(0);
    aready = 1'b1; lat = 1;
    for (int i = 0; i < 8; i++) send(16'(i));
    tick(2);
    check("t1_wr_count", 32'(waddr_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("t1_waddr", 32'(waddr_q[i]), 32'(i));
    check("t1_rd_issued", 32'(raddr_q.size()), 32'd4);
    check("t1_level", 32'(v_level), 32'd4);
    m_ready = 1'b1;
    wait_pops(8, "t1_pops");
    for (int i = 0; i < 8; i++) begin
      check("t1_mdata", 32'(pop_q[i]), 32'(i));
      check("t1_raddr", 32'(raddr_q[i]), 32'(i));
    end
    check("t1_level_end", 32'(v_level), 32'd0);
    check("t1_m_valid_end", 32'(v_m_valid), 32'd0);

    // Test 2: preload so both requests stay pending, then check round-robin and a stall.
    do_reset(0);
    aready = 1'b1; lat = 1; s_data = 16'h2222; s_valid = 1'b1;
    tick(12);
    check("t2_pre_writes", 32'(waddr_q.size()), 32'd8);
    check("t2_pre_reads", 32'(raddr_q.size()), 32'd4);
    m_ready = 1'b1;
    grant_q.delete();
    tick(8);
    check("t2_grant_count", 32'(grant_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("t2_grant", 32'(grant_q[i]), 32'(i % 2 == 0));
    aready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("t2_stall_awe", 32'(v_awe), 32'd1);
      check("t2_stall_aaddr", 32'(v_aaddr), 32'd12);
      check("t2_stall_level", 32'(v_level), 32'd4);
      @(posedge clk);
    end
    #1;
    check("t2_stall_no_accept", 32'(grant_q.size()), 32'd8);
    aready = 1'b1;
    tick(1);
    check("t2_resume_waddr", 32'(waddr_q[$]), 32'd12);
    s_valid = 1'b0;

    // Test 3: 20 words, consumer stalled, latency 3: credit must cap outstanding reads at 4.
    do_reset(0);
    aready = 1'b1; lat = 3;
    for (int i = 0; i < 20; i++) send(16'h0300 + 16'(i));
    tick(6);
    check("t3_wr_count", 32'(waddr_q.size()), 32'd20);
    check("t3_rd_issued", 32'(raddr_q.size()), 32'd4);
    check("t3_level", 32'(v_level), 32'd16);
    m_ready = 1'b1;
    wait_pops(20, "t3_pops");
    for (int i = 0; i < 20; i++) check("t3_mdata", 32'(pop_q[i]), 32'(16'h0300 + 16'(i)));
    check("t3_credit_max", 32'(max_out <= 4), 32'd1);
    check("t3_credit_reached", 32'(max_out), 32'd4);

    // Test 4: 16-word buffer; 4 reads drain into the FIFO, so 20 writes fill it and wrap.
    do_reset(1);
    aready = 1'b1; lat = 1;
    for (int i = 0; i < 20; i++) send(16'h0400 + 16'(i));
    tick(2);
    check("t4_wr_count", 32'(waddr_q.size()), 32'd20);
    for (int i = 0; i < 20; i++) check("t4_waddr_wrap", 32'(waddr_q[i]), 32'(i % 16));
    check("t4_level_full", 32'(v_level), 32'd16);
    s_data = 16'h04FF; s_valid = 1'b1;
    @(negedge clk); #1;
    check("t4_s_ready_full", 32'(v_s_ready), 32'd0);
    check("t4_ovf_before", 32'(v_overflow), 32'd0);
    @(posedge clk); #1;
    check("t4_ovf_set", 32'(v_overflow), 32'd1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_pops(20, "t4_pops");
    for (int i = 0; i < 20; i++) begin
      check("t4_mdata", 32'(pop_q[i]), 32'(16'h0400 + 16'(i)));
      check("t4_raddr_wrap", 32'(raddr_q[i]), 32'(i % 16));
    end
    check("t4_ovf_sticky", 32'(v_overflow), 32'd1);
    check("t4_level_end", 32'(v_level), 32'd0);

    // Test 5 (same 16-word instance): 3 reads in flight, flush before any response.
    m_ready = 1'b0; lat = 8;
    waddr_q.delete(); raddr_q.delete(); pop_q.delete();
    mv_seen = 1'b0; rd_resp_cnt = 0;
    send(16'h0501); send(16'h0502); send(16'h0503);
    tick(1);
    check("t5_rd_issued", 32'(raddr_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("t5_waddr", 32'(waddr_q[i]), 32'(4 + i));
      check("t5_raddr", 32'(raddr_q[i]), 32'(4 + i));
    end
    flush = 1'b1; s_data = 16'h5AAA; s_valid = 1'b1;
    @(negedge clk); #1;
    check("t5_flush_avalid", 32'(v_avalid), 32'd0);
    check("t5_flush_s_ready", 32'(v_s_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; s_valid = 1'b0;
    check("t5_level", 32'(v_level), 32'd0);
    check("t5_overflow", 32'(v_overflow), 32'd0);
    m_ready = 1'b1;
    tick(16);
    check("t5_resp_delivered", 32'(rd_resp_cnt), 32'd3);
    check("t5_m_valid_never", 32'(mv_seen), 32'd0);
    check("t5_no_pops", 32'(pop_q.size()), 32'd0);
    lat = 1;
    send(16'h5555);
    check("t5_next_waddr", 32'(waddr_q[$]), 32'd0);
    wait_pops(1, "t5_post_pop");
    check("t5_post_data", 32'(pop_q[0]), 32'h5555);

    // Test 6: reset mid-stream with read data buffered and a read still in flight.
    do_reset(0);
    aready = 1'b1; lat = 3;
    for (int i = 0; i < 4; i++) send(16'h0600 + 16'(i));
    s_data = 16'h06FF; s_valid = 1'b1;
    check("t6_pre_m_valid", 32'(v_m_valid), 32'd1);
    check("t6_pre_inflight", 32'(rq.size() > 0), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_s_ready", 32'(v_s_ready), 32'd0);
    check("t6_rst_avalid", 32'(v_avalid), 32'd0);
    check("t6_rst_m_valid", 32'(v_m_valid), 32'd0);
    check("t6_rst_level", 32'(v_level), 32'd0);
    check("t6_rst_overflow", 32'(v_overflow), 32'd0);
    tick(2);
    s_valid = 1'b0;
    mv_seen = 1'b0;
    rst = 1'b0;
    tick(10);
    check("t6_post_m_valid", 32'(mv_seen), 32'd0);
    check("t6_post_level", 32'(v_level), 32'd0);
    check("t6_post_avalid", 32'(v_avalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
